// File: rtl/reg_bus_arb_pkg.sv
// Shared widths and FSM encoding for the register-bus arbiter.
// Round-robin arbitration is selected with the ARB_ROUND_ROBIN_EN macro.
package pwm_regbus_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUS_A  = 3'd1,
    S_BUS_B  = 3'd2,
    S_HOLD_A = 3'd3,
    S_HOLD_B = 3'd4
  } state_t;

endpackage

// File: rtl/reg_bus_arb_if.sv
// Requester A/B handshakes plus the register-bank port of the arbiter.
// slave = arbiter view, master = environment (requesters and bank) view.
interface reg_bus_arb_if;
  import pwm_regbus_pkg::*;

  logic              a_req, a_we, a_lock, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;

  logic              b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;

  logic              read, write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_write, data_read;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_lock,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    input  data_read,
    output a_gnt, a_rdata, a_rvalid,
    output b_gnt, b_rdata, b_rvalid,
    output read, write, addr, data_write
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_lock,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    output data_read,
    input  a_gnt, a_rdata, a_rvalid,
    input  b_gnt, b_rdata, b_rvalid,
    input  read, write, addr, data_write
  );

endinterface

// File: rtl/reg_bus_arb_pick.sv
// Winner selection for simultaneous requests in IDLE.
// ARB_ROUND_ROBIN_EN adds a last-served register; otherwise A has fixed priority.
module arb_pick (
`ifdef ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst_n,
  input  logic served_a,
  input  logic served_b,
`endif
  input  logic a_req,
  input  logic b_req,
  output logic pick_b
);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_b;

  // Reset value B makes A the first winner of a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_b <= 1'b1;
    else if (served_a) last_b <= 1'b0;
    else if (served_b) last_b <= 1'b1;
  end

  assign pick_b = b_req & (~a_req | ~last_b);
`else
  assign pick_b = b_req & ~a_req;
`endif

endmodule

// File: rtl/reg_bus_arb.sv
// Two-requester register-bus arbiter with lock/hold and idle-timeout release.
// Build option ARB_ROUND_ROBIN_EN: round-robin tie-break instead of A priority.
module reg_bus_arb
  import pwm_regbus_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_bus_arb_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              load_a, load_b, pick_b;
  logic              gnt_a, gnt_b, in_bus;

  logic              we_p0, lock_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              a_vld_p1, b_vld_p1;
  logic [DATA_W-1:0] a_rdata_p1, b_rdata_p1;

  assign gnt_a   = (state == S_BUS_A);
  assign gnt_b   = (state == S_BUS_B);
  assign in_bus  = gnt_a | gnt_b;
  assign cnt_inc = cnt + 1'b1;

  arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .clk      (clk),
    .rst_n    (rst_n),
    .served_a (gnt_a),
    .served_b (gnt_b),
`endif
    .a_req    (bus.a_req),
    .b_req    (bus.b_req),
    .pick_b   (pick_b)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_a    = 1'b0;
    load_b    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          if (pick_b) begin
            load_b    = 1'b1;
            state_nxt = S_BUS_B;
          end else begin
            load_a    = 1'b1;
            state_nxt = S_BUS_A;
          end
        end
      end
      S_BUS_A: begin
        cnt_nxt   = '0;
        state_nxt = lock_p0 ? S_HOLD_A : S_IDLE;
      end
      S_BUS_B: begin
        cnt_nxt   = '0;
        state_nxt = lock_p0 ? S_HOLD_B : S_IDLE;
      end
      // The owner's own request bypasses arbitration; the other side is ignored.
      S_HOLD_A: begin
        if (bus.a_req) begin
          load_a    = 1'b1;
          state_nxt = S_BUS_A;
        end else if (!bus.a_lock || cnt_inc == CNT_W'(HOLD_MAX)) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_HOLD_B: begin
        if (bus.b_req) begin
          load_b    = 1'b1;
          state_nxt = S_BUS_B;
        end else if (!bus.b_lock || cnt_inc == CNT_W'(HOLD_MAX)) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: control state, lock flag and read-return registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lock_p0    <= 1'b0;
      a_vld_p1   <= 1'b0;
      b_vld_p1   <= 1'b0;
      a_rdata_p1 <= '0;
      b_rdata_p1 <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      if (load_a)      lock_p0 <= bus.a_lock;
      else if (load_b) lock_p0 <= bus.b_lock;
      a_vld_p1 <= gnt_a & ~we_p0;
      b_vld_p1 <= gnt_b & ~we_p0;
      if (gnt_a && !we_p0) a_rdata_p1 <= bus.data_read;
      if (gnt_b && !we_p0) b_rdata_p1 <= bus.data_read;
    end
  end

  // Stage p0: access payload, only consumed while in a BUS state.
  always_ff @(posedge clk) begin
    if (load_a) begin
      we_p0    <= bus.a_we;
      addr_p0  <= bus.a_addr;
      wdata_p0 <= bus.a_wdata;
    end else if (load_b) begin
      we_p0    <= bus.b_we;
      addr_p0  <= bus.b_addr;
      wdata_p0 <= bus.b_wdata;
    end
  end

  assign bus.a_gnt      = gnt_a;
  assign bus.b_gnt      = gnt_b;
  assign bus.read       = in_bus & ~we_p0;
  assign bus.write      = in_bus & we_p0;
  assign bus.addr       = in_bus ? addr_p0  : '0;
  assign bus.data_write = in_bus ? wdata_p0 : '0;
  assign bus.a_rvalid   = a_vld_p1;
  assign bus.b_rvalid   = b_vld_p1;
  assign bus.a_rdata    = a_rdata_p1;
  assign bus.b_rdata    = b_rdata_p1;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed bench for reg_bus_arb with a grant-order scoreboard.
// Honors ARB_ROUND_ROBIN_EN to pick the expected tie-break order.
module tb_reg_bus_arb;

  logic clk, rst_n;
  reg_bus_arb_if bif();

  reg_bus_arb #(.HOLD_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // Register bank: fixed combinational contents.
  assign bif.data_read = 8'h3E ^ {2'b00, bif.addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       who_b;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } txn_t;

  txn_t       exp_q[$];
  txn_t       mon_t;
  int         total = 0;
  int         bad   = 0;
  logic       pend_a = 1'b0, pend_b = 1'b0;
  logic [7:0] pend_a_data, pend_b_data;
  int         ai, bi, n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic who_b, input logic we,
                               input logic [5:0] addr, input logic [7:0] wdata);
    txn_t t;
    t.who_b = who_b;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = 8'h3E ^ {2'b00, addr};
    exp_q.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every bus cycle must match the next expected access.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pend_a = 1'b0;
      pend_b = 1'b0;
    end else begin
      chk("a_rvalid", bif.a_rvalid, pend_a);
      chk("b_rvalid", bif.b_rvalid, pend_b);
      if (pend_a) chk("a_rdata", bif.a_rdata, pend_a_data);
      if (pend_b) chk("b_rdata", bif.b_rdata, pend_b_data);
      pend_a = 1'b0;
      pend_b = 1'b0;
      chk("rw_excl", bif.read & bif.write, 0);
      if (bif.a_gnt || bif.b_gnt) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", {bif.a_gnt, bif.b_gnt}, 0);
        end else begin
          mon_t = exp_q.pop_front();
          chk("gnt_owner", {bif.a_gnt, bif.b_gnt}, {~mon_t.who_b, mon_t.who_b});
          chk("strobe", {bif.read, bif.write}, {~mon_t.we, mon_t.we});
          chk("bus_addr", bif.addr, mon_t.addr);
          if (mon_t.we) chk("bus_wdata", bif.data_write, mon_t.wdata);
          else if (mon_t.who_b) begin pend_b = 1'b1; pend_b_data = mon_t.rdata; end
          else begin pend_a = 1'b1; pend_a_data = mon_t.rdata; end
        end
      end else begin
        chk("idle_bus", {bif.read, bif.write, bif.addr, bif.data_write}, 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bif.a_req = 0; bif.a_we = 0; bif.a_addr = '0; bif.a_wdata = '0; bif.a_lock = 0;
    bif.b_req = 0; bif.b_we = 0; bif.b_addr = '0; bif.b_wdata = '0; bif.b_lock = 0;

    // Reset state
    tick(); tick();
    chk("rst_gnt", {bif.a_gnt, bif.b_gnt}, 0);
    chk("rst_strobe", {bif.read, bif.write, bif.addr, bif.data_write}, 0);
    chk("rst_rdata", {bif.a_rdata, bif.b_rdata}, 0);
    chk("rst_rvalid", {bif.a_rvalid, bif.b_rvalid}, 0);
    rst_n = 1'b1;
    tick();

    // A single write
    push(1'b0, 1'b1, 6'h05, 8'hA5);
    bif.a_req = 1; bif.a_we = 1; bif.a_addr = 6'h05; bif.a_wdata = 8'hA5; bif.a_lock = 0;
    tick();
    chk("a_wr_n1", {bif.a_gnt, bif.write, bif.addr, bif.data_write}, {1'b1, 1'b1, 6'h05, 8'hA5});
    bif.a_req = 0;
    tick();
    chk("a_gnt_one_cycle", {bif.a_gnt, bif.write}, 0);

    // B single read
    push(1'b1, 1'b0, 6'h02, 8'h00);
    bif.b_req = 1; bif.b_we = 0; bif.b_addr = 6'h02; bif.b_lock = 0;
    tick();
    chk("b_rd_n1", {bif.b_gnt, bif.read, bif.addr}, {1'b1, 1'b1, 6'h02});
    bif.b_req = 0;
    tick();
    chk("b_rd_n2", {bif.b_rvalid, bif.b_rdata}, {1'b1, 8'h3C});
    tick();
    chk("b_rdata_held", {bif.b_rvalid, bif.b_rdata}, {1'b0, 8'h3C});

    // Simultaneous requests, two per requester
`ifdef ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b1, 6'h21, 8'h11);
    push(1'b1, 1'b1, 6'h31, 8'h22);
    push(1'b0, 1'b1, 6'h22, 8'h12);
    push(1'b1, 1'b1, 6'h32, 8'h23);
`else
    push(1'b0, 1'b1, 6'h21, 8'h11);
    push(1'b0, 1'b1, 6'h22, 8'h12);
    push(1'b1, 1'b1, 6'h31, 8'h22);
    push(1'b1, 1'b1, 6'h32, 8'h23);
`endif
    ai = 0; bi = 0;
    bif.a_req = 1; bif.a_we = 1; bif.a_addr = 6'h21; bif.a_wdata = 8'h11;
    bif.b_req = 1; bif.b_we = 1; bif.b_addr = 6'h31; bif.b_wdata = 8'h22;
    for (n = 0; n < 40 && (ai < 2 || bi < 2); n++) begin
      tick();
      if (bif.a_gnt) begin
        ai++;
        if (ai < 2) begin bif.a_addr = 6'h22; bif.a_wdata = 8'h12; end
        else bif.a_req = 0;
      end
      if (bif.b_gnt) begin
        bi++;
        if (bi < 2) begin bif.b_addr = 6'h32; bif.b_wdata = 8'h23; end
        else bif.b_req = 0;
      end
    end
    chk("tie_seq_done", {ai[1:0], bi[1:0]}, {2'd2, 2'd2});
    tick();

    // Locked A sequence holds B off until release
    push(1'b0, 1'b1, 6'h10, 8'h51);
    push(1'b0, 1'b1, 6'h11, 8'h52);
    push(1'b1, 1'b1, 6'h20, 8'h53);
    bif.a_req = 1; bif.a_we = 1; bif.a_addr = 6'h10; bif.a_wdata = 8'h51; bif.a_lock = 1;
    tick();
    chk("lock_a1_gnt", bif.a_gnt, 1);
    bif.a_req = 0;
    bif.b_req = 1; bif.b_we = 1; bif.b_addr = 6'h20; bif.b_wdata = 8'h53; bif.b_lock = 0;
    tick();
    tick();
    chk("lock_b_blocked", bif.b_gnt, 0);
    bif.a_req = 1; bif.a_addr = 6'h11; bif.a_wdata = 8'h52; bif.a_lock = 0;
    tick();
    chk("lock_a2_gnt", {bif.a_gnt, bif.b_gnt}, 2'b10);
    bif.a_req = 0;
    tick();
    chk("lock_release_idle", bif.b_gnt, 0);
    tick();
    chk("lock_b_after", bif.b_gnt, 1);
    bif.b_req = 0;
    tick();

    // Hold timeout with a pending B read
    push(1'b0, 1'b1, 6'h12, 8'h77);
    push(1'b1, 1'b0, 6'h07, 8'h00);
    bif.a_req = 1; bif.a_we = 1; bif.a_addr = 6'h12; bif.a_wdata = 8'h77; bif.a_lock = 1;
    tick();
    chk("hold_a_gnt", bif.a_gnt, 1);
    bif.a_req = 0;
    bif.b_req = 1; bif.b_we = 0; bif.b_addr = 6'h07;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bif.b_gnt && n < 30);
    chk("hold_timeout_cycles", n, 10);
    bif.b_req = 0; bif.a_lock = 0;
    tick();
    tick();

    // Reset during a B read
    push(1'b1, 1'b0, 6'h09, 8'h00);
    bif.b_req = 1; bif.b_we = 0; bif.b_addr = 6'h09;
    tick();
    chk("rst_mid_gnt", {bif.b_gnt, bif.read}, 2'b11);
    bif.b_req = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_strobe", {bif.b_gnt, bif.read, bif.write, bif.addr}, 0);
    tick();
    chk("rst_mid_rvalid1", bif.b_rvalid, 0);
    tick();
    chk("rst_mid_rvalid2", {bif.b_rvalid, bif.b_rdata}, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_mid_rvalid3", bif.b_rvalid, 0);

    // First access after reset
    push(1'b0, 1'b0, 6'h04, 8'h00);
    bif.a_req = 1; bif.a_we = 0; bif.a_addr = 6'h04; bif.a_lock = 0;
    tick();
    chk("post_rst_gnt", {bif.a_gnt, bif.read}, 2'b11);
    bif.a_req = 0;
    tick();
    chk("post_rst_rdata", {bif.a_rvalid, bif.a_rdata}, {1'b1, 8'h3A});

    for (n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    chk("queue_drained", exp_q.size(), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
